// File: rtl/display_mux_4.sv
// display_mux_4 -- time-multiplexed driver for a 4-digit, active-low 7-segment display.
//
// A prescaler divides the clock into digit slots of CLK_DIV cycles. Each slot begins with
// BLANK_CYC dead cycles, with all anodes off, so the previous digit cannot ghost into the next.
// The four digit patterns are copied into snapshot registers once per frame: on the first edge
// after reset and at the end of the thousands slot. The display therefore never shows a frame
// that mixes old and new data. With LZ_EN set, leading zeros on the upper digits are blanked.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   en         : display enable; when low, the outputs go dark but scanning continues
//   D_un/D_de/D_ce/D_mil : active-low segment patterns, [0:N_out-1] = a..g
//                          (units, tens, hundreds, thousands)
//   seg        : shared active-low segment bus (registered)
//   an         : active-low anodes, an[0] = units .. an[3] = thousands (registered)
//   digit_idx  : current slot index
//   frame_tick : one-cycle pulse in the cycle after each snapshot load
module display_mux_4 #(
    parameter int unsigned      N_out     = 7,
    parameter int unsigned      CLK_DIV   = 50000,
    parameter int unsigned      BLANK_CYC = 500,
    parameter bit               LZ_EN     = 1'b1,
    parameter logic [0:N_out-1] ZERO_PAT  = 7'b0000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [0:N_out-1] D_un,
    input  logic [0:N_out-1] D_de,
    input  logic [0:N_out-1] D_ce,
    input  logic [0:N_out-1] D_mil,
    output logic [0:N_out-1] seg,
    output logic [3:0]       an,
    output logic [1:0]       digit_idx,
    output logic             frame_tick
);

    localparam int unsigned      CntW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0]  CntMax   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  BlankEnd = CntW'(BLANK_CYC);
    localparam logic [0:N_out-1] AllOnes  = '1;

    // State
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             first_q;
    logic [0:N_out-1] snap_q [4];
    logic             frame_tick_q;
    logic [3:0]       an_q, an_d;
    logic [0:N_out-1] seg_q, seg_d;

    // Combinational helpers
    logic cnt_wrap;
    logic load;
    logic z1, z2, z3;
    logic blank1, blank2, blank3;
    logic blank_sel;

    // Prescaler and slot index
    always_comb begin
        cnt_wrap = (cnt_q == CntMax);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
        // The snapshot is taken on the first edge out of reset, and again on the last cycle
        // of the thousands slot, so the new frame starts cleanly at slot 0.
        load     = first_q | (cnt_wrap & (idx_q == 2'd3));
    end

    // Leading-zero suppression works down from the thousands digit. A digit is blanked only
    // if every more-significant digit is blanked too. The units digit is never blanked, so a
    // value of 0 still shows a single "0".
    always_comb begin
        z1     = (snap_q[1] == ZERO_PAT);
        z2     = (snap_q[2] == ZERO_PAT);
        z3     = (snap_q[3] == ZERO_PAT);
        blank3 = LZ_EN && z3;
        blank2 = blank3 && z2;
        blank1 = blank2 && z1;
    end

    always_comb begin
        blank_sel = 1'b0;
        unique case (idx_q)
            2'd0: blank_sel = 1'b0;
            2'd1: blank_sel = blank1;
            2'd2: blank_sel = blank2;
            2'd3: blank_sel = blank3;
            default: blank_sel = 1'b0;
        endcase
    end

    // Next-cycle outputs. The dead cycles at the start of every slot keep all anodes off
    // between two different lit digits.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = AllOnes;
        if (en && (cnt_q >= BlankEnd)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank_sel ? AllOnes : snap_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            first_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= AllOnes;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= AllOnes;
            end
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            first_q      <= 1'b0;
            frame_tick_q <= load;
            an_q         <= an_d;
            seg_q        <= seg_d;
            if (load) begin
                snap_q[0] <= D_un;
                snap_q[1] <= D_de;
                snap_q[2] <= D_ce;
                snap_q[3] <= D_mil;
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

`ifndef SYNTHESIS
    an_at_most_one_low: assert property (@(posedge clk) disable iff (!rst)
        $countones(~an) <= 1);
`endif

endmodule

// File: tb/tb_display_mux_4.sv
module tb_display_mux_4;

    localparam int unsigned NOut     = 7;
    localparam int unsigned ClkDiv   = 4;
    localparam int unsigned BlankCyc = 1;
    localparam logic [0:6]  ZeroPat  = 7'b0000001;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en  = 1'b1;
    logic [0:NOut-1] d_un, d_de, d_ce, d_mil;
    logic [0:NOut-1] seg;
    logic [3:0]      an;
    logic [1:0]      digit_idx;
    logic            frame_tick;

    display_mux_4 #(
        .N_out    (NOut),
        .CLK_DIV  (ClkDiv),
        .BLANK_CYC(BlankCyc),
        .LZ_EN    (1'b1),
        .ZERO_PAT (ZeroPat)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .D_un      (d_un),
        .D_de      (d_de),
        .D_ce      (d_ce),
        .D_mil     (d_mil),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;   // clock edges since the last reset release

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       ft;
    } exp_t;

    exp_t scan_tab [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, k, act, req);
        end
    endtask

    // Advance one edge and land 1 time unit after it, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int t);
        while (k < t) step();
    endtask

    task automatic set_in(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                          input logic [6:0] m);
        d_un  = u;
        d_de  = t;
        d_ce  = h;
        d_mil = m;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        step();
        step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        rst = 1'b1;
        k   = 0;
    endtask

    task automatic run_scan();
        for (int i = 0; i < 17; i++) begin
            step();
            chk("scan_an", 32'(an), 32'(scan_tab[i].an));
            chk("scan_seg", 32'(seg), 32'(scan_tab[i].seg));
            chk("scan_idx", 32'(digit_idx), 32'(scan_tab[i].idx));
            chk("scan_ft", 32'(frame_tick), 32'(scan_tab[i].ft));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_dig;
        int blank_run;
        int dig;

        // After reset release, with 4F/12/06/4C: edge k shows the slot that held the state
        // cnt=(k-1)%4, idx=((k-1)/4)%4, and it is dark when that cnt was 0.
        scan_tab[0]  = '{4'hF, 7'h7F, 2'd0, 1'b1};
        scan_tab[1]  = '{4'hE, 7'h4F, 2'd0, 1'b0};
        scan_tab[2]  = '{4'hE, 7'h4F, 2'd0, 1'b0};
        scan_tab[3]  = '{4'hE, 7'h4F, 2'd1, 1'b0};
        scan_tab[4]  = '{4'hF, 7'h7F, 2'd1, 1'b0};
        scan_tab[5]  = '{4'hD, 7'h12, 2'd1, 1'b0};
        scan_tab[6]  = '{4'hD, 7'h12, 2'd1, 1'b0};
        scan_tab[7]  = '{4'hD, 7'h12, 2'd2, 1'b0};
        scan_tab[8]  = '{4'hF, 7'h7F, 2'd2, 1'b0};
        scan_tab[9]  = '{4'hB, 7'h06, 2'd2, 1'b0};
        scan_tab[10] = '{4'hB, 7'h06, 2'd2, 1'b0};
        scan_tab[11] = '{4'hB, 7'h06, 2'd3, 1'b0};
        scan_tab[12] = '{4'hF, 7'h7F, 2'd3, 1'b0};
        scan_tab[13] = '{4'h7, 7'h4C, 2'd3, 1'b0};
        scan_tab[14] = '{4'h7, 7'h4C, 2'd3, 1'b0};
        scan_tab[15] = '{4'h7, 7'h4C, 2'd0, 1'b1};
        scan_tab[16] = '{4'hF, 7'h7F, 2'd0, 1'b0};

        // Scan order
        set_in(7'h4F, 7'h12, 7'h06, 7'h4C);
        en = 1'b1;
        hold_reset();
        run_scan();

        // Leading zeros
        set_in(7'h4F, 7'h12, ZeroPat, ZeroPat);
        hold_reset();
        step_to(2);  chk("lz_un_an", 32'(an), 32'hE);  chk("lz_un_seg", 32'(seg), 32'h4F);
        step_to(6);  chk("lz_de_an", 32'(an), 32'hD);  chk("lz_de_seg", 32'(seg), 32'h12);
        step_to(10); chk("lz_ce_an", 32'(an), 32'hB);  chk("lz_ce_seg", 32'(seg), 32'h7F);
        step_to(14); chk("lz_mil_an", 32'(an), 32'h7); chk("lz_mil_seg", 32'(seg), 32'h7F);
        set_in(ZeroPat, ZeroPat, ZeroPat, ZeroPat);   // loaded at edge 16
        step_to(16); chk("lz_old_mil", 32'(seg), 32'h7F);
        step_to(18); chk("lz0_un_an", 32'(an), 32'hE); chk("lz0_un_seg", 32'(seg), 32'h01);
        step_to(22); chk("lz0_de_seg", 32'(seg), 32'h7F);
        step_to(26); chk("lz0_ce_seg", 32'(seg), 32'h7F);
        step_to(30); chk("lz0_mil_an", 32'(an), 32'h7); chk("lz0_mil_seg", 32'(seg), 32'h7F);

        // Tear-free update: change units while the tens slot is active
        set_in(7'h4F, 7'h12, 7'h06, 7'h4C);
        hold_reset();
        step_to(2); chk("tf_old_un", 32'(seg), 32'h4F);
        step_to(5); chk("tf_mid_idx", 32'(digit_idx), 32'h1);
        d_un = 7'h30;
        step_to(14); chk("tf_mil_seg", 32'(seg), 32'h4C);
        step_to(15); chk("tf_ft_pre", 32'(frame_tick), 32'h0);
        step_to(16); chk("tf_ft", 32'(frame_tick), 32'h1);
        step_to(17); chk("tf_ft_post", 32'(frame_tick), 32'h0);
        step_to(18); chk("tf_new_an", 32'(an), 32'hE); chk("tf_new_seg", 32'(seg), 32'h30);

        // Enable dropped for 6 cycles
        set_in(7'h4F, 7'h12, 7'h06, 7'h4C);
        hold_reset();
        step_to(5);
        en = 1'b0;
        for (int c = 6; c <= 11; c++) begin
            step_to(c);
            chk("en_an", 32'(an), 32'hF);
            chk("en_seg", 32'(seg), 32'h7F);
            chk("en_idx", 32'(digit_idx), 32'((c / 4) % 4));
        end
        en = 1'b1;
        step_to(12); chk("en_resume_an", 32'(an), 32'hB); chk("en_resume_seg", 32'(seg), 32'h06);
        chk("en_resume_idx", 32'(digit_idx), 32'h3);
        step_to(14); chk("en_mil_an", 32'(an), 32'h7); chk("en_mil_seg", 32'(seg), 32'h4C);

        // Asynchronous reset between edges at cnt=2, idx=2
        hold_reset();
        step_to(10);
        chk("ar_pre_idx", 32'(digit_idx), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_an", 32'(an), 32'hF);
        chk("ar_idx", 32'(digit_idx), 32'h0);
        chk("ar_seg", 32'(seg), 32'h7F);
        step();
        rst = 1'b1;
        k   = 0;
        run_scan();

        // Random run: one anode at most, and dark cycles between different digits
        last_dig  = -1;
        blank_run = 0;
        for (int i = 0; i < 10000; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                set_in(ZeroPat, 7'($urandom), ZeroPat, ZeroPat);
            end else begin
                set_in(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
            end
            step();
            chk("rnd_onehot", 32'($countones(~an) <= 1), 32'h1);
            if (an == 4'hF) begin
                blank_run++;
            end else begin
                dig = 0;
                for (int b = 0; b < 4; b++) begin
                    if (!an[b]) dig = b;
                end
                if (last_dig >= 0 && dig != last_dig) begin
                    chk("rnd_gap", 32'(blank_run >= int'(BlankCyc)), 32'h1);
                end
                last_dig  = dig;
                blank_run = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
